// File: rtl/enc_pkg.sv
// Shared types and sizes for the serial index encoder.
package enc_pkg;

  localparam int ENC_N = 32;
  localparam int ENC_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic             vld;
    logic [ENC_W-1:0] idx;
    logic             last;
  } idx_rsp_t;

  // Drop the lowest set bit of a vector.
  function automatic logic [ENC_N-1:0] clr_lowest(input logic [ENC_N-1:0] v);
    return v & (v - ENC_N'(1));
  endfunction

endpackage

// File: rtl/prio_enc32.sv
// Lowest-set-bit priority encoder; inverse of the 5-to-32 write-select decoder.
module prio_enc32
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] in,
  output logic [ENC_W-1:0] idx,
  output logic             any,
  output logic             one_hot
);

  always_comb begin
    idx = '0;
    // Scan high to low so the lowest set bit is the last to write idx.
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (in[i]) idx = ENC_W'(i);
    end
  end

  assign any     = |in;
  assign one_hot = any && (clr_lowest(in) == '0);

endmodule

// File: rtl/serial_index_encoder.sv
// Drains a multi-hot request vector as a stream of indices, lowest first.
module serial_index_encoder
  import enc_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_vec,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         busy
);

  enc_state_e   state;
  logic [N-1:0] pend;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         enc_one;
  idx_rsp_t     rsp;

  prio_enc32 u_prio (
    .in      (pend),
    .idx     (enc_idx),
    .any     (enc_any),
    .one_hot (enc_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pend  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // An all-zero vector is accepted and simply dropped.
          if (req_valid && (req_vec != '0)) begin
            pend  <= req_vec;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (idx_ready) begin
            pend <= clr_lowest(pend);
            if (enc_one) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs follow the async-reset state flop, so reset drops them immediately.
  always_comb begin
    rsp.vld  = (state == ST_DRAIN) && enc_any;
    rsp.idx  = rsp.vld ? enc_idx : '0;
    rsp.last = rsp.vld && enc_one;
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign idx_valid = rsp.vld;
  assign idx       = rsp.idx;
  assign idx_last  = rsp.last;

endmodule
